scan_num: RTL
=============

Name: scan_num

Overview:
- Parametrised successor to the serial debug unit's command scanner. Consumes ASCII bytes from the UART receive path and returns one of three results to the debug controller:
  - a raw byte;
  - a hexadecimal number;
  - a decimal number.
- Adds the following to the previous scanner: configurable result width and digit count, decimal mode, backspace editing, error reporting, multi-cycle radix conversion, and an explicit valid/ready receive handshake.

Parameters:
- WIDTH, 32: result width in bits, >= 8.
- MAX_DIGITS, 10: maximum digits buffered per token, 1..16.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- rx_data  input  8  received ASCII byte.
- rx_vld  input  1  rx_data valid.
- rx_rdy  output  1  scanner accepts byte; transfer occurs when rx_vld && rx_rdy at posedge.
- req  input  1  controller request, 4-phase, held until ack seen.
- mode  input  2  sampled at request start: 00 raw byte, 01 hex, 10 decimal, 11 treated as hex.
- ack  output  1  result valid; held high until req low.
- dout  output  WIDTH  result value.
- empty  output  1  token terminated with zero digits.
- err  output  2  bit0: illegal character seen; bit1: overflow (digit count or value).

Behaviour:
- Reset: all outputs 0 (rx_rdy, ack, dout, empty, err); state IDLE; digit count 0; buffer and accumulator 0.
- States: IDLE, RECV, CONV, DONE. All outputs are registered.
- IDLE:
  - rx_rdy=0, ack=0.
  - When req=1 && ack=0: latch mode; clear buffer, count, dout, empty, err; go to RECV.
  - Bytes are never consumed in IDLE.
- RECV: rx_rdy=1. Each accepted byte is handled as follows.
  - Mode 00 (raw byte): dout={0,rx_data}, including CR/space; rx_rdy drops; go to DONE.
  - Hex/dec, space 0x20 with count=0: ignored (leading blanks).
  - Hex/dec, LF 0x0A: always ignored.
  - Hex/dec, CR 0x0D with count=0: empty=1, dout=0; go to DONE.
  - Hex/dec, CR or space with count>0: go to CONV.
  - Hex/dec, backspace 0x08 or 0x7F: if count>0, remove the newest digit and decrement count; if count=0, ignore.
  - Hex/dec, legal digit: if count<MAX_DIGITS, append nibble and increment count; otherwise set err[1] and discard the digit.
    - Hex: 0-9, A-F, a-f.
    - Dec: 0-9 only.
  - Hex/dec, any other byte: set err[0] and discard; scanning continues.
- CONV:
  - rx_rdy=0.
  - Processes one digit per cycle, oldest first: acc = acc*base + digit, base 16 or 10.
  - Decimal multiply implemented as shift-add (acc<<3 + acc<<1); no multiplier.
  - Accumulator is WIDTH+4 bits wide. Any nonzero bit above WIDTH-1 after a step sets err[1] (sticky); dout keeps the low WIDTH bits (truncated).
  - Takes exactly count cycles, then dout=acc[WIDTH-1:0]; go to DONE.
- DONE:
  - ack=1; dout, empty and err are stable.
  - When req=0: go to IDLE, with ack=0 on the same edge.
  - A new request requires req to go low and then high again.
- Abort: req=0 while in RECV or CONV returns to IDLE next edge. rx_rdy=0, ack stays 0, partial data discarded.
- Latency, terminator accept to ack:
  - raw byte or empty token: 1 cycle;
  - numeric token: count+1 cycles.
- err bits are sticky within one request and cleared only at the next request start.
- Asynchronous reset mid-operation returns to IDLE immediately; no partial ack.

Test Plan:
- Hex "1A2b\r" -> dout=0x00001A2B, err=00, empty=0; ack 5 cycles after CR accepted.
- Decimal "  4294967295 " -> dout=0xFFFFFFFF, err=00. Decimal "4294967296\r" -> err=10, dout=0x00000000.
- Hex "12", BS(0x08), "3\r" -> dout=0x13. BS with count=0 followed by "\r" -> empty=1, dout=0.
- Hex "1G2\r" -> dout=0x12, err=01. Hex 11 digits "FFFFFFFFFFF\r" with MAX_DIGITS=10 -> err=10 (digit overflow and value overflow), dout=0xFFFFFFFF.
- Raw mode, byte 0x0D -> dout=0x0D, empty=0, ack 1 cycle later; next byte not consumed until new req (rx_rdy=0).
- req dropped after "12" -> IDLE, ack never rises. Re-request hex "7\r" -> dout=0x7, err=00. rstn pulsed during CONV -> all outputs 0.

Source files
------------

// File: rtl/scan_num_if.sv
// Receive-byte handshake and controller request/result bundle for the scan_num token scanner.
interface scan_num_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       rx_data;
  logic             rx_vld;
  logic             rx_rdy;
  logic             req;
  logic [1:0]       mode;
  logic             ack;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic [1:0]       err;

  modport master (
    output rx_data, rx_vld, req, mode,
    input  rx_rdy, ack, dout, empty, err
  );

  modport slave (
    input  rx_data, rx_vld, req, mode,
    output rx_rdy, ack, dout, empty, err
  );
endinterface

// File: rtl/scan_num.sv
// ASCII token scanner: returns a raw byte, or a hex/decimal number converted one digit per cycle,
// to the debug controller over a 4-phase req/ack handshake.
module scan_num #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic      clk,
  input  logic      rstn,
  scan_num_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = 4 * MAX_DIGITS;
  localparam int AW = WIDTH + 4;
  localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RECV, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, top_idx;
  logic [BW-1:0]    digs, digs_nxt;
  logic [AW-1:0]    acc, acc_nxt, acc_step;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             rx_rdy_q, rx_rdy_nxt;
  logic             ack_q, ack_nxt;
  logic             empty_q, empty_nxt;
  logic [1:0]       err_q, err_nxt;
  logic [4:0]       dig_dec;
  logic [3:0]       cur_dig;
  logic             is_dec, is_cr, is_sp, is_lf, is_bs;

  function automatic logic [4:0] decode_digit(input logic [7:0] c, input logic dec_only);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if (!dec_only && ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  // Digits are shifted in at the low nibble, so the oldest digit sits at nibble cnt-1.
  always_comb begin
    is_dec   = (mode_q == 2'b10);
    is_cr    = (bus.rx_data == 8'h0D);
    is_sp    = (bus.rx_data == 8'h20);
    is_lf    = (bus.rx_data == 8'h0A);
    is_bs    = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);
    dig_dec  = decode_digit(bus.rx_data, is_dec);
    top_idx  = (cnt == '0) ? '0 : cnt - ONE;
    cur_dig  = digs[int'(top_idx) * 4 +: 4];
    if (is_dec)
      acc_step = (acc << 3) + (acc << 1) + AW'(cur_dig);
    else
      acc_step = (acc << 4) + AW'(cur_dig);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      mode_q   <= 2'b00;
      cnt      <= '0;
      digs     <= '0;
      acc      <= '0;
      dout_q   <= '0;
      rx_rdy_q <= 1'b0;
      ack_q    <= 1'b0;
      empty_q  <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      cnt      <= cnt_nxt;
      digs     <= digs_nxt;
      acc      <= acc_nxt;
      dout_q   <= dout_nxt;
      rx_rdy_q <= rx_rdy_nxt;
      ack_q    <= ack_nxt;
      empty_q  <= empty_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt;
    digs_nxt  = digs;
    acc_nxt   = acc;
    dout_nxt  = dout_q;
    empty_nxt = empty_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (bus.req && !ack_q) begin
          mode_nxt  = bus.mode;
          cnt_nxt   = '0;
          digs_nxt  = '0;
          acc_nxt   = '0;
          dout_nxt  = '0;
          empty_nxt = 1'b0;
          err_nxt   = 2'b00;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (!bus.req) begin
          state_nxt = IDLE;
        end else if (bus.rx_vld && rx_rdy_q) begin
          if (mode_q == 2'b00) begin
            dout_nxt  = WIDTH'(bus.rx_data);
            state_nxt = DONE;
          end else if (is_lf || (is_sp && cnt == '0)) begin
          end else if (is_cr && cnt == '0) begin
            empty_nxt = 1'b1;
            dout_nxt  = '0;
            state_nxt = DONE;
          end else if (is_cr || is_sp) begin
            acc_nxt   = '0;
            state_nxt = CONV;
          end else if (is_bs) begin
            if (cnt != '0) begin
              cnt_nxt  = cnt - ONE;
              digs_nxt = digs >> 4;
            end
          end else if (dig_dec[4]) begin
            if (cnt < MAXC) begin
              cnt_nxt  = cnt + ONE;
              digs_nxt = (digs << 4) | BW'(dig_dec[3:0]);
            end else begin
              err_nxt[1] = 1'b1;
            end
          end else begin
            err_nxt[0] = 1'b1;
          end
        end
      end
      // The accumulator is re-truncated every step so the top nibble flags overflow exactly.
      CONV: begin
        if (!bus.req) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt = {4'b0000, acc_step[WIDTH-1:0]};
          cnt_nxt = cnt - ONE;
          if (|acc_step[AW-1:WIDTH])
            err_nxt[1] = 1'b1;
          if (cnt == ONE) begin
            dout_nxt  = acc_step[WIDTH-1:0];
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.req)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    rx_rdy_nxt = (state_nxt == RECV);
    ack_nxt    = (state == DONE) && bus.req;
  end

  assign bus.rx_rdy = rx_rdy_q;
  assign bus.ack    = ack_q;
  assign bus.dout   = dout_q;
  assign bus.empty  = empty_q;
  assign bus.err    = err_q;
endmodule
